// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address-check helper for dmem_port
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        ACK   = 2'b11
    } state_t;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Byte-offset bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // An access faults when misaligned or when any address bit above the word index is set
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr, input int depth_log2);
        logic [ADDR_W-1:0] hi;
        hi = addr >> (depth_log2 + 2);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - read/write request-acknowledge bundle between memory stage and dmem_port
interface dmem_if;
    import dmem_pkg::*;

    logic              mem_read_req;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read_ack;
    logic              mem_write_req;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_ack;
    logic              busy;
    logic              access_err;

    modport master (
        output mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
        input  mem_read_data, mem_read_ack, mem_write_ack, busy, access_err
    );

    modport slave (
        input  mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
        output mem_read_data, mem_read_ack, mem_write_ack, busy, access_err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with registered read, contents not reset
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    // Write when enabled; read is registered every cycle (read-before-write on collision)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - latency-programmable data-memory responder with fault flagging
module dmem_port #(
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    import dmem_pkg::*;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  fault_q;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    logic                  rd_ack_q;
    logic                  wr_ack_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  err_q;
    logic                  busy_q;

    // RAM address: the incoming read index while idle so data is ready even at latency 1,
    // the latched index for the rest of the transaction
    always_comb begin
        ram_addr = idx_q;
        if (state == IDLE) begin
            ram_addr = bus.mem_read_addr[DEPTH_LOG2+1:2];
        end
        ram_we = (state == WRITE) && (cnt == '0) && !fault_q && !reset;
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Transaction FSM: accept (write first), count down latency, complete, single-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_write_req) begin
                        idx_q   <= bus.mem_write_addr[DEPTH_LOG2+1:2];
                        wdata_q <= bus.mem_write_data;
                        fault_q <= addr_fault(bus.mem_write_addr, DEPTH_LOG2);
                        cnt     <= WR_LOAD;
                        state   <= WRITE;
                        busy_q  <= 1'b1;
                    end else if (bus.mem_read_req) begin
                        idx_q   <= bus.mem_read_addr[DEPTH_LOG2+1:2];
                        fault_q <= addr_fault(bus.mem_read_addr, DEPTH_LOG2);
                        cnt     <= RD_LOAD;
                        state   <= READ;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        rd_data_q <= fault_q ? '0 : ram_rdata;
                        rd_ack_q  <= 1'b1;
                        err_q     <= fault_q;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WRITE: begin
                    if (cnt == '0) begin
                        wr_ack_q <= 1'b1;
                        err_q    <= fault_q;
                        state    <= ACK;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read_ack  = rd_ack_q;
    assign bus.mem_write_ack = wr_ack_q;
    assign bus.mem_read_data = rd_data_q;
    assign bus.access_err    = err_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - directed self-checking bench for dmem_port
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        rreq, wreq;
    logic [31:0] raddr, waddr, wdata;
    int          sel;

    logic        o_rack, o_wack, o_err, o_busy;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus1 ();
    dmem_if bus2 ();

    assign bus0.mem_read_req   = rreq && (sel == 0);
    assign bus0.mem_write_req  = wreq && (sel == 0);
    assign bus0.mem_read_addr  = raddr;
    assign bus0.mem_write_addr = waddr;
    assign bus0.mem_write_data = wdata;

    assign bus1.mem_read_req   = rreq && (sel == 1);
    assign bus1.mem_write_req  = wreq && (sel == 1);
    assign bus1.mem_read_addr  = raddr;
    assign bus1.mem_write_addr = waddr;
    assign bus1.mem_write_data = wdata;

    assign bus2.mem_read_req   = rreq && (sel == 2);
    assign bus2.mem_write_req  = wreq && (sel == 2);
    assign bus2.mem_read_addr  = raddr;
    assign bus2.mem_write_addr = waddr;
    assign bus2.mem_write_data = wdata;

    dmem_port #(.DEPTH_LOG2(10), .READ_LATENCY(2),  .WRITE_LATENCY(1))  u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_port #(.DEPTH_LOG2(10), .READ_LATENCY(2),  .WRITE_LATENCY(3))  u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_port #(.DEPTH_LOG2(10), .READ_LATENCY(15), .WRITE_LATENCY(15)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always_comb begin
        o_rack  = bus0.mem_read_ack;
        o_wack  = bus0.mem_write_ack;
        o_rdata = bus0.mem_read_data;
        o_err   = bus0.access_err;
        o_busy  = bus0.busy;
        if (sel == 1) begin
            o_rack  = bus1.mem_read_ack;
            o_wack  = bus1.mem_write_ack;
            o_rdata = bus1.mem_read_data;
            o_err   = bus1.access_err;
            o_busy  = bus1.busy;
        end else if (sel == 2) begin
            o_rack  = bus2.mem_read_ack;
            o_wack  = bus2.mem_write_ack;
            o_rdata = bus2.mem_read_data;
            o_err   = bus2.access_err;
            o_busy  = bus2.busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge of an IDLE cycle; lat counts negedges until the ack is seen
    // (latency L gives L+1). Returns at the negedge of the following IDLE cycle.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output logic [31:0] rd, output logic err, output logic ack_after);
        if (wr) begin
            wreq = 1'b1; waddr = addr; wdata = data;
        end else begin
            rreq = 1'b1; raddr = addr;
        end
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (wr ? o_wack : o_rack) break;
        end
        rd  = o_rdata;
        err = o_err;
        wreq = 1'b0;
        rreq = 1'b0;
        @(negedge clk);
        ack_after = wr ? o_wack : o_rack;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vt [12];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err, ack_after;
        int          n;
        int          k;
        int          busylow;
        int          ack_cyc [3];
        logic [31:0] exp_stream [3];
        logic        saw_ack;

        // exp_rd on writes is the held value of the previous read
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
        vt[4]  = '{1'b1, 32'h0001_0000, 32'h5555_5555, 32'h0000_0000, 1'b1};
        vt[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vt[6]  = '{1'b1, 32'h0000_0FFC, 32'h0000_0077, 32'hA5A5_A5A5, 1'b0};
        vt[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0077, 1'b0};
        vt[8]  = '{1'b1, 32'h0000_1000, 32'h0000_0099, 32'h0000_0077, 1'b1};
        vt[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vt[10] = '{1'b1, 32'h8000_0000, 32'h0000_0BAD, 32'hA5A5_A5A5, 1'b1};
        vt[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};

        reset = 1'b1; rreq = 1'b0; wreq = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("reset_read_ack",  {31'b0, o_rack}, 32'h0);
        chk("reset_write_ack", {31'b0, o_wack}, 32'h0);
        chk("reset_read_data", o_rdata, 32'h0);
        chk("reset_access_err", {31'b0, o_err}, 32'h0);
        chk("reset_busy",      {31'b0, o_busy}, 32'h0);

        // Table: READ_LATENCY=2, WRITE_LATENCY=1
        for (int i = 0; i < 12; i++) begin
            txn(vt[i].wr, vt[i].addr, vt[i].data, lat, rd, err, ack_after);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].wr ? 32'd2 : 32'd3);
            chk($sformatf("vec%0d_read_data", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_access_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_ack_one_cycle", i), {31'b0, ack_after}, 32'h0);
        end

        // Both requests at once: write wins, read is taken in the next IDLE cycle
        wreq = 1'b1; waddr = 32'h20; wdata = 32'h1;
        rreq = 1'b1; raddr = 32'h20;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (o_wack || o_rack) break;
        end
        chk("both_write_ack", {31'b0, o_wack}, 32'h1);
        chk("both_no_read_ack", {31'b0, o_rack}, 32'h0);
        chk("both_write_latency", n, 32'd2);
        wreq = 1'b0;
        @(negedge clk);
        chk("both_idle_busy", {31'b0, o_busy}, 32'h0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (o_rack) break;
        end
        chk("both_read_latency", n, 32'd3);
        chk("both_read_data", o_rdata, 32'h1);
        rreq = 1'b0;
        @(negedge clk);

        // Address and data change after accept must not matter
        wreq = 1'b1; waddr = 32'h30; wdata = 32'h1357_2468;
        @(negedge clk);
        waddr = 32'h34; wdata = 32'hFFFF_FFFF;
        n = 1;
        while (n < 40) begin
            if (o_wack) break;
            @(negedge clk);
            n++;
        end
        chk("late_change_write_latency", n, 32'd2);
        wreq = 1'b0;
        @(negedge clk);
        txn(1'b0, 32'h30, 32'h0, lat, rd, err, ack_after);
        chk("late_change_read_data", rd, 32'h1357_2468);

        // Continuous read request stream at 0x0, 0x4, 0x8
        txn(1'b1, 32'h4, 32'h4444_4444, lat, rd, err, ack_after);
        txn(1'b1, 32'h8, 32'h8888_8888, lat, rd, err, ack_after);
        exp_stream[0] = 32'hA5A5_A5A5;
        exp_stream[1] = 32'h4444_4444;
        exp_stream[2] = 32'h8888_8888;
        rreq = 1'b1; raddr = 32'h0;
        k = 0; busylow = 0;
        ack_cyc[0] = 0; ack_cyc[1] = 0; ack_cyc[2] = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_rack) begin
                ack_cyc[k] = c;
                chk($sformatf("stream%0d_data", k), o_rdata, exp_stream[k]);
                k++;
                if (k == 3) begin
                    rreq = 1'b0;
                    break;
                end
                raddr = 32'(k * 4);
            end
            if (k >= 1 && !o_busy) busylow++;
        end
        chk("stream_ack_count", k, 32'd3);
        // L cycles in READ, one in ACK, one in IDLE between accepts
        chk("stream_spacing_01", ack_cyc[1] - ack_cyc[0], 32'd4);
        chk("stream_spacing_12", ack_cyc[2] - ack_cyc[1], 32'd4);
        chk("stream_busy_low_cycles", busylow, 32'd2);
        @(negedge clk);

        // Reset mid-write on WRITE_LATENCY=3 instance
        sel = 1;
        txn(1'b1, 32'h40, 32'h1111_1111, lat, rd, err, ack_after);
        chk("l3_write_latency", lat, 32'd4);
        txn(1'b0, 32'h40, 32'h0, lat, rd, err, ack_after);
        chk("l3_read_data", rd, 32'h1111_1111);
        wreq = 1'b1; waddr = 32'h40; wdata = 32'h0000_CAFE;
        @(negedge clk);
        reset = 1'b1; wreq = 1'b0;
        @(negedge clk);
        chk("abort_read_ack",  {31'b0, o_rack}, 32'h0);
        chk("abort_write_ack", {31'b0, o_wack}, 32'h0);
        chk("abort_read_data", o_rdata, 32'h0);
        chk("abort_access_err", {31'b0, o_err}, 32'h0);
        chk("abort_busy",      {31'b0, o_busy}, 32'h0);
        reset = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_wack) saw_ack = 1'b1;
        end
        chk("abort_no_late_ack", {31'b0, saw_ack}, 32'h0);
        txn(1'b0, 32'h40, 32'h0, lat, rd, err, ack_after);
        chk("abort_ram_unchanged", rd, 32'h1111_1111);

        // Maximum latency instance
        sel = 2;
        txn(1'b1, 32'h8, 32'hF00D_F00D, lat, rd, err, ack_after);
        chk("l15_write_latency", lat, 32'd16);
        chk("l15_write_ack_one_cycle", {31'b0, ack_after}, 32'h0);
        txn(1'b0, 32'h8, 32'h0, lat, rd, err, ack_after);
        chk("l15_read_latency", lat, 32'd16);
        chk("l15_read_data", rd, 32'hF00D_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
